l1_access_driver: RTL and testbench
===================================

// Module: l1_access_driver
// PURPOSE
//  Initiator for the L1 cache lookup handshake: accepts 32-bit access requests from a
//  trace/host port, splits each address into tag/index/block_offset and pulses find_start.
//  Then tracks done_L1/updated to completion and returns a per-access hit/miss response.
//  Keeps access/miss counters and a timeout error flag. Sits between the trace source and the L1 cache.
// PARAMETERS
//  WAY              4    associativity of target cache (sets SET only)
//  BLOCK_SIZE_BYTE  16   block size; OFFSET_W = log2(BLOCK_SIZE_BYTE) = 4
//  CACHE_SIZE_BYTE  256  cache size; SET = CACHE/(BLOCK*WAY) = 4, INDEX_W = log2(SET) = 2
//  TAG_W            derived 32-INDEX_W-OFFSET_W = 26
//  TIMEOUT          255  max cycles waited for done_L1 or for updated
// PORTS
//  clk             in   1        single clock, rising edge
//  reset           in   1        asynchronous, active-low reset
//  req_valid       in   1        host access request valid
//  req_ready       out  1        driver can accept request
//  req_addr        in   32       host byte address
//  addr            out  32       registered address to cache
//  tag             out  TAG_W    addr[31:INDEX_W+OFFSET_W]
//  index           out  INDEX_W  addr[INDEX_W+OFFSET_W-1:OFFSET_W]
//  block_offset    out  OFFSET_W addr[OFFSET_W-1:0]
//  find_start      out  1        one-cycle lookup start pulse
//  done_L1         in   1        cache lookup complete (1-cycle level)
//  found_in_cache  in   1        hit flag, valid while done_L1=1
//  updated         in   1        cache replacement/LRU update complete (1-cycle level)
//  rsp_valid       out  1        one-cycle response pulse
//  rsp_hit         out  1        1=hit, 0=miss; held until next rsp_valid
//  rsp_addr        out  32       address of responded access
//  access_count    out  16       completed accesses, saturating
//  miss_count      out  16       completed misses, saturating
//  timeout_err     out  1        sticky; set on handshake timeout
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; all outputs 0 except req_ready=1; counters, timer cleared.
//  - States: IDLE, ISSUE, WAIT_DONE, WAIT_UPD, GAP.
//  - IDLE: req_ready=1. req_valid&req_ready at edge -> latch req_addr into addr/tag/index/offset;
//    go ISSUE. tag/index/block_offset are pure slices of registered addr and stay stable until next accept.
//  - ISSUE: find_start=1 for exactly this cycle; timer cleared; -> WAIT_DONE.
//  - WAIT_DONE: on done_L1=1 sample found_in_cache into hit_r; -> WAIT_UPD.
//    found_in_cache is ignored when done_L1=0.
//  - WAIT_UPD: on updated=1 -> rsp_valid=1 next cycle with rsp_hit=hit_r and rsp_addr=addr;
//    access_count+1; miss_count+1 if !hit_r; -> GAP.
//  - GAP: one idle cycle so the cache returns to its idle state before the next find_start; -> IDLE.
//  - Rate: at most one access in flight; next find_start >= 2 cycles after updated seen.
//  - done_L1 and updated asserted in the same cycle while in WAIT_DONE: sample hit, complete
//    directly (skip WAIT_UPD).
//  - done_L1/updated seen in IDLE/ISSUE/GAP: ignored, no count change.
//  - Timeout: timer increments each cycle in WAIT_DONE/WAIT_UPD and resets on state change.
//    At TIMEOUT: set timeout_err, emit rsp_valid with rsp_hit=0, no counter update, -> GAP.
//  - Counters saturate at 16'hFFFF; miss_count <= access_count always.
//  - Reset mid-access: aborts immediately, no rsp_valid, find_start low.
//    Only reset clears timeout_err.
// TESTING
//  1. Reset low then high, req_addr=32'h0000_1234 -> find_start 1 cycle after accept;
//     tag=26'h48, index=2'h3, block_offset=4'h4.
//  2. Cache model returns done_L1 with found_in_cache=0, then updated 1 cycle later ->
//     rsp_valid, rsp_hit=0, access_count=1, miss_count=1.
//  3. Same address again with hit -> rsp_hit=1, access_count=2, miss_count=1; check GAP cycle
//     (req_ready low the cycle after rsp_valid).
//  4. Back-to-back req_valid held high for 3 addrs -> exactly 3 find_start pulses, each spaced
//     >= 2 cycles after prior updated.
//  5. Model never raises done_L1 -> after 255 cycles timeout_err=1, rsp_valid with rsp_hit=0;
//     counters unchanged; next request still served.
//  6. Assert reset while in WAIT_UPD -> all outputs 0, req_ready=1, no rsp_valid; counters 0.

Source files
------------

// File: rtl/l1_access_driver_if.sv
// Bundle of the host request/response and L1 lookup handshake signals.
// master = access driver side, slave = host/cache side.
interface l1_access_driver_if #(
  parameter int WAY             = 4,
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int CACHE_SIZE_BYTE = 256
);
  localparam int OFFSET_W = $clog2(BLOCK_SIZE_BYTE);
  localparam int INDEX_W  = $clog2(CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY));
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;

  logic                req_valid;
  logic                req_ready;
  logic [31:0]         req_addr;
  logic [31:0]         addr;
  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  index;
  logic [OFFSET_W-1:0] block_offset;
  logic                find_start;
  logic                done_L1;
  logic                found_in_cache;
  logic                updated;
  logic                rsp_valid;
  logic                rsp_hit;
  logic [31:0]         rsp_addr;
  logic [15:0]         access_count;
  logic [15:0]         miss_count;
  logic                timeout_err;

  modport master (
    input  req_valid, req_addr, done_L1, found_in_cache, updated,
    output req_ready, addr, tag, index, block_offset, find_start,
           rsp_valid, rsp_hit, rsp_addr, access_count, miss_count, timeout_err
  );

  modport slave (
    output req_valid, req_addr, done_L1, found_in_cache, updated,
    input  req_ready, addr, tag, index, block_offset, find_start,
           rsp_valid, rsp_hit, rsp_addr, access_count, miss_count, timeout_err
  );
endinterface

// File: rtl/l1_access_driver.sv
// Drives one L1 lookup at a time: latches a host address, pulses find_start,
// waits for done_L1/updated (with timeout) and returns a hit/miss response.
module l1_access_driver #(
  parameter int WAY             = 4,
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int CACHE_SIZE_BYTE = 256,
  parameter int TIMEOUT         = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  l1_access_driver_if.master    bus
);
  localparam int OFFSET_W = $clog2(BLOCK_SIZE_BYTE);
  localparam int INDEX_W  = $clog2(CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY));
  localparam int TIMER_W  = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, WAIT_UPD, GAP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_addr;
  logic [31:0]         r_rsp_addr;
  logic                r_hit;
  logic                r_rsp_valid;
  logic                r_rsp_hit;
  logic                r_timeout_err;
  logic [TIMER_W-1:0]  r_timer;
  logic [15:0]         r_access_count;
  logic [15:0]         r_miss_count;
  logic                w_accept;
  logic                w_complete;
  logic                w_timeout;
  logic                w_hit_next;
  logic                w_timer_exp;
  logic                w_waiting;

  assign w_timer_exp = (r_timer == TIMER_LAST);
  assign w_waiting   = (r_state == WAIT_DONE) || (r_state == WAIT_UPD);

  // A lookup that reports done and updated together completes without visiting WAIT_UPD.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_complete = 1'b0;
    w_timeout  = 1'b0;
    w_hit_next = r_hit;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          w_next   = ISSUE;
        end
      end
      ISSUE: w_next = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.done_L1) begin
          w_hit_next = bus.found_in_cache;
          if (bus.updated) begin
            w_complete = 1'b1;
            w_next     = GAP;
          end else begin
            w_next = WAIT_UPD;
          end
        end else if (w_timer_exp) begin
          w_timeout = 1'b1;
          w_next    = GAP;
        end
      end
      WAIT_UPD: begin
        if (bus.updated) begin
          w_complete = 1'b1;
          w_next     = GAP;
        end else if (w_timer_exp) begin
          w_timeout = 1'b1;
          w_next    = GAP;
        end
      end
      GAP:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_addr         <= '0;
      r_rsp_addr     <= '0;
      r_hit          <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_hit      <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_timer        <= '0;
      r_access_count <= '0;
      r_miss_count   <= '0;
    end else begin
      r_state     <= w_next;
      r_hit       <= w_hit_next;
      r_rsp_valid <= w_complete || w_timeout;
      if (w_accept) r_addr <= bus.req_addr;
      if ((w_next != r_state) || !w_waiting) r_timer <= '0;
      else                                   r_timer <= r_timer + 1'b1;
      if (w_complete) begin
        r_rsp_hit  <= w_hit_next;
        r_rsp_addr <= r_addr;
        if (r_access_count != 16'hFFFF) r_access_count <= r_access_count + 16'd1;
        if (!w_hit_next && (r_miss_count != 16'hFFFF)) r_miss_count <= r_miss_count + 16'd1;
      end else if (w_timeout) begin
        r_rsp_hit     <= 1'b0;
        r_rsp_addr    <= r_addr;
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.req_ready    = (r_state == IDLE);
  assign bus.find_start   = (r_state == ISSUE);
  assign bus.addr         = r_addr;
  assign bus.tag          = r_addr[31:INDEX_W+OFFSET_W];
  assign bus.index        = r_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign bus.block_offset = r_addr[OFFSET_W-1:0];
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_hit      = r_rsp_hit;
  assign bus.rsp_addr     = r_rsp_addr;
  assign bus.access_count = r_access_count;
  assign bus.miss_count   = r_miss_count;
  assign bus.timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_l1_access_driver.sv
// Directed bench for l1_access_driver: the bench plays host and L1 cache,
// driving inputs #1 after each rising edge and checking outputs at the same point.
module tb_l1_access_driver;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cycleNo;
  int   updCycle;
  int   fsPulses;
  int   fsBase;
  int   waitCycles;
  logic [31:0] b2bAddr [3];

  l1_access_driver_if bus ();

  l1_access_driver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.find_start === 1'b1) fsPulses++;

  task automatic step();
    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  // Starts in IDLE and returns in the GAP cycle that carries the response.
  task automatic applyStimulus(input logic [31:0] a, input logic hit, input logic sameCycle);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    step();
    bus.req_valid = 1'b0;
    step();
    bus.done_L1        = 1'b1;
    bus.found_in_cache = hit;
    bus.updated        = sameCycle;
    step();
    bus.done_L1        = 1'b0;
    bus.found_in_cache = 1'b0;
    if (!sameCycle) begin
      bus.updated = 1'b1;
      step();
    end
    bus.updated = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cycleNo     = 0;
    updCycle    = 0;
    fsPulses    = 0;
    b2bAddr[0]  = 32'h0000_0100;
    b2bAddr[1]  = 32'h0000_0210;
    b2bAddr[2]  = 32'h0000_0320;
    rst_n              = 1'b1;
    bus.req_valid      = 1'b0;
    bus.req_addr       = '0;
    bus.done_L1        = 1'b0;
    bus.found_in_cache = 1'b0;
    bus.updated        = 1'b0;
    #1 rst_n = 1'b0;
    step();
    step();
    checkOutput("rst_req_ready",  bus.req_ready, 1);
    checkOutput("rst_find_start", bus.find_start, 0);
    checkOutput("rst_rsp_valid",  bus.rsp_valid, 0);
    checkOutput("rst_addr",       bus.addr, 0);
    checkOutput("rst_access",     bus.access_count, 0);
    checkOutput("rst_timeout",    bus.timeout_err, 0);
    rst_n = 1'b1;
    step();

    // Accept 0x1234 and check the address split and the start pulse.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_1234;
    step();
    bus.req_valid = 1'b0;
    checkOutput("t1_find_start", bus.find_start, 1);
    checkOutput("t1_req_ready",  bus.req_ready, 0);
    checkOutput("t1_addr",       bus.addr, 32'h0000_1234);
    checkOutput("t1_tag",        bus.tag, 32'h48);
    checkOutput("t1_index",      bus.index, 32'h3);
    checkOutput("t1_offset",     bus.block_offset, 32'h4);
    step();
    checkOutput("t1_start_once", bus.find_start, 0);
    bus.found_in_cache = 1'b1;
    step();
    bus.done_L1        = 1'b1;
    bus.found_in_cache = 1'b0;
    step();
    bus.done_L1 = 1'b0;
    bus.updated = 1'b1;
    step();
    bus.updated = 1'b0;
    checkOutput("t2_rsp_valid", bus.rsp_valid, 1);
    checkOutput("t2_rsp_hit",   bus.rsp_hit, 0);
    checkOutput("t2_rsp_addr",  bus.rsp_addr, 32'h0000_1234);
    checkOutput("t2_access",    bus.access_count, 1);
    checkOutput("t2_miss",      bus.miss_count, 1);
    step();
    checkOutput("t2_pulse_once", bus.rsp_valid, 0);

    // Same address as a hit; the response cycle is the GAP cycle.
    applyStimulus(32'h0000_1234, 1'b1, 1'b0);
    checkOutput("t3_rsp_valid", bus.rsp_valid, 1);
    checkOutput("t3_rsp_hit",   bus.rsp_hit, 1);
    checkOutput("t3_access",    bus.access_count, 2);
    checkOutput("t3_miss",      bus.miss_count, 1);
    checkOutput("t3_gap_ready", bus.req_ready, 0);
    step();
    checkOutput("t3_idle_ready", bus.req_ready, 1);
    checkOutput("t3_hit_held",   bus.rsp_hit, 1);

    // Cache handshakes while idle must be ignored.
    bus.done_L1 = 1'b1;
    bus.updated = 1'b1;
    step();
    bus.done_L1 = 1'b0;
    bus.updated = 1'b0;
    step();
    checkOutput("idle_ignore_rsp", bus.rsp_valid, 0);
    checkOutput("idle_ignore_acc", bus.access_count, 2);

    // done_L1 and updated together complete directly from WAIT_DONE.
    applyStimulus(32'hABCD_EF00, 1'b0, 1'b1);
    checkOutput("same_rsp_valid", bus.rsp_valid, 1);
    checkOutput("same_rsp_addr",  bus.rsp_addr, 32'hABCD_EF00);
    checkOutput("same_access",    bus.access_count, 3);
    checkOutput("same_miss",      bus.miss_count, 2);
    step();

    // Back-to-back requests with req_valid held high.
    fsBase        = fsPulses;
    bus.req_valid = 1'b1;
    bus.req_addr  = b2bAddr[0];
    for (int k = 0; k < 3; k++) begin
      waitCycles = 0;
      while (bus.find_start !== 1'b1 && waitCycles < 10) begin
        step();
        waitCycles++;
      end
      checkOutput("b2b_start", bus.find_start, 1);
      checkOutput("b2b_addr",  bus.addr, b2bAddr[k]);
      if (k > 0) checkOutput("b2b_spacing", 32'(cycleNo - updCycle >= 2), 1);
      if (k < 2) bus.req_addr = b2bAddr[k+1];
      else       bus.req_valid = 1'b0;
      step();
      bus.done_L1        = 1'b1;
      bus.found_in_cache = (k == 2);
      step();
      bus.done_L1        = 1'b0;
      bus.found_in_cache = 1'b0;
      bus.updated        = 1'b1;
      updCycle           = cycleNo;
      step();
      bus.updated = 1'b0;
      checkOutput("b2b_rsp_valid", bus.rsp_valid, 1);
    end
    step();
    step();
    checkOutput("b2b_pulses", 32'(fsPulses - fsBase), 3);
    checkOutput("b2b_access", bus.access_count, 6);
    checkOutput("b2b_miss",   bus.miss_count, 4);

    // Cache never answers: timeout after 255 cycles in WAIT_DONE.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0BAD;
    step();
    bus.req_valid = 1'b0;
    checkOutput("to_find_start", bus.find_start, 1);
    repeat (255) step();
    checkOutput("to_not_yet_err", bus.timeout_err, 0);
    checkOutput("to_not_yet_rsp", bus.rsp_valid, 0);
    step();
    checkOutput("to_err",       bus.timeout_err, 1);
    checkOutput("to_rsp_valid", bus.rsp_valid, 1);
    checkOutput("to_rsp_hit",   bus.rsp_hit, 0);
    checkOutput("to_rsp_addr",  bus.rsp_addr, 32'h0000_0BAD);
    checkOutput("to_access",    bus.access_count, 6);
    checkOutput("to_miss",      bus.miss_count, 4);
    step();
    checkOutput("to_sticky", bus.timeout_err, 1);
    applyStimulus(32'h0000_0C00, 1'b1, 1'b0);
    checkOutput("to_next_rsp",    bus.rsp_valid, 1);
    checkOutput("to_next_hit",    bus.rsp_hit, 1);
    checkOutput("to_next_access", bus.access_count, 7);
    checkOutput("to_next_sticky", bus.timeout_err, 1);
    step();

    // Reset while waiting for updated aborts the access.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0D40;
    step();
    bus.req_valid = 1'b0;
    step();
    bus.done_L1 = 1'b1;
    step();
    bus.done_L1 = 1'b0;
    rst_n       = 1'b0;
    #1;
    checkOutput("mid_rst_ready",   bus.req_ready, 1);
    checkOutput("mid_rst_start",   bus.find_start, 0);
    checkOutput("mid_rst_addr",    bus.addr, 0);
    checkOutput("mid_rst_access",  bus.access_count, 0);
    checkOutput("mid_rst_miss",    bus.miss_count, 0);
    checkOutput("mid_rst_timeout", bus.timeout_err, 0);
    bus.updated = 1'b1;
    step();
    bus.updated = 1'b0;
    checkOutput("mid_rst_no_rsp", bus.rsp_valid, 0);
    rst_n = 1'b1;
    step();
    checkOutput("post_rst_rsp",   bus.rsp_valid, 0);
    checkOutput("post_rst_ready", bus.req_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
